// File: rtl/serial_frame_rx_if.sv
// Handshake bundle for serial_frame_rx: bit-serial input side and parallel byte output side.
interface serial_frame_rx_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic              s_data_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic              parity_err_o;
    logic              frame_err_o;

    // Receiver side
    modport slave (
        input  s_data_i,
        input  s_valid_i,
        input  m_ready_i,
        output s_ready_o,
        output m_data_o,
        output m_valid_o,
        output parity_err_o,
        output frame_err_o
    );

    // Bit source / byte sink side
    modport master (
        output s_data_i,
        output s_valid_i,
        output m_ready_i,
        input  s_ready_o,
        input  m_data_o,
        input  m_valid_o,
        input  parity_err_o,
        input  frame_err_o
    );

endinterface

// File: rtl/serial_frame_rx.sv
// Framed serial bit receiver: start/data/parity/stop recovery, error flags,
// and a small byte FIFO in front of a parallel valid/ready port.
module serial_frame_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    serial_frame_rx_if.slave bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_ok_q, par_ok_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic s_ready_c;
    logic m_valid_c;
    logic accept_c;
    logic push_c;
    logic pop_c;

    // Handshake qualifiers derived from the registered FIFO count
    always_comb begin
        s_ready_c = (count_q != CNT_W'(FIFO_DEPTH));
        m_valid_c = (count_q != '0);
        accept_c  = bus.s_valid_i && s_ready_c;
        pop_c     = m_valid_c && bus.m_ready_i;
    end

    // Frame FSM next-state: only accepted bits advance; stop bit decides push or error
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        push_c       = 1'b0;

        if (accept_c) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.s_data_i) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (bit_cnt_q == BIT_W'(i)) begin
                            shift_d[i] = bus.s_data_i;
                        end
                    end
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        state_d   = PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                PARITY: begin
                    par_ok_d = (bus.s_data_i == (^shift_q));
                    state_d  = STOP;
                end
                STOP: begin
                    // A low stop bit is an error, never a fresh start bit
                    push_c       = bus.s_data_i && par_ok_q;
                    frame_err_d  = !bus.s_data_i;
                    parity_err_d = !par_ok_q;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO next-state: circular buffer, simultaneous push/pop leaves count unchanged
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Frame FSM and error flag registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // FIFO storage, pointers and occupancy registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.s_ready_o    = s_ready_c;
    assign bus.m_valid_o    = m_valid_c;
    assign bus.m_data_o     = mem_q[rd_ptr_q];
    assign bus.parity_err_o = parity_err_q;
    assign bus.frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed and table-driven bench for serial_frame_rx.
module tb_serial_frame_rx;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    serial_frame_rx #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    logic [7:0] got [$];

    typedef struct {
        logic [7:0] data;
        bit         flip_par;
        bit         stop;
        int         pre_idle;
        bit         exp_push;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t vecs [8];

    // Output monitor: records popped bytes and error pulses, mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_valid_o && bus.m_ready_i) got.push_back(bus.m_data_o);
            if (bus.parity_err_o) perr_cnt++;
            if (bus.frame_err_o) ferr_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one bit and hold it until accepted; optional random idle gap first
    task automatic send_bit(input logic b, input bit gap);
        int waited;
        if (gap && ($urandom_range(0, 1) == 1)) begin
            bus.s_valid_i = 1'b0;
            bus.s_data_i  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = b;
        waited = 0;
        @(negedge clk);
        while (!bus.s_ready_o && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 300) chk("bit_accept_timeout", 32'(bus.s_ready_o), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input logic stop, input bit gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit((^d) ^ flip, gap);
        send_bit(stop, gap);
    endtask

    task automatic wait_got(input int target, input int budget);
        int n;
        n = 0;
        while (got.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] exp_q [$];
        bit rnd_done;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h12, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h55, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0};

        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 1'b0;
        bus.m_ready_i = 1'b1;

        // Reset state, with inputs active during reset
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready_o), 32'd1);
        chk("rst_m_data", 32'(bus.m_data_o), 32'd0);
        chk("rst_perr", 32'(bus.parity_err_o), 32'd0);
        chk("rst_ferr", 32'(bus.frame_err_o), 32'd0);
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven frames with immediate sink
        base     = got.size();
        perr_cnt = 0;
        ferr_cnt = 0;
        exp_q.delete();
        foreach (vecs[k]) begin
            for (int j = 0; j < vecs[k].pre_idle; j++) send_bit(1'b1, 1'b0);
            send_frame(vecs[k].data, vecs[k].flip_par, vecs[k].stop, 1'b0);
            bus.s_valid_i = 1'b0;
            if (vecs[k].exp_push) exp_q.push_back(vecs[k].data);
            @(negedge clk);
            chk($sformatf("vec%0d_m_valid", k), 32'(bus.m_valid_o), 32'(vecs[k].exp_push));
            if (vecs[k].exp_push) chk($sformatf("vec%0d_m_data", k), 32'(bus.m_data_o), 32'(vecs[k].data));
            chk($sformatf("vec%0d_perr", k), 32'(bus.parity_err_o), 32'(vecs[k].exp_perr));
            chk($sformatf("vec%0d_ferr", k), 32'(bus.frame_err_o), 32'(vecs[k].exp_ferr));
            @(negedge clk);
            chk($sformatf("vec%0d_m_valid_after", k), 32'(bus.m_valid_o), 32'd0);
            chk($sformatf("vec%0d_perr_after", k), 32'(bus.parity_err_o), 32'd0);
            chk($sformatf("vec%0d_ferr_after", k), 32'(bus.frame_err_o), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("tab_perr_total", 32'(perr_cnt), 32'd2);
        chk("tab_ferr_total", 32'(ferr_cnt), 32'd2);
        chk("tab_out_count", 32'(got.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && (base + i) < got.size(); i++)
            chk($sformatf("tab_out%0d", i), 32'(got[base + i]), 32'(exp_q[i]));

        // Backpressure: six back-to-back frames into a four-entry FIFO
        bus.m_ready_i = 1'b0;
        base = got.size();
        for (int k = 0; k < 4; k++) send_frame(8'(8'h10 + k), 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_s_ready_full", 32'(bus.s_ready_o), 32'd0);
        fork
            begin
                send_frame(8'h14, 1'b0, 1'b1, 1'b0);
                send_frame(8'h15, 1'b0, 1'b1, 1'b0);
                bus.s_valid_i = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_stall_s_ready", 32'(bus.s_ready_o), 32'd0);
                chk("bp_stall_m_valid", 32'(bus.m_valid_o), 32'd1);
                chk("bp_stall_head", 32'(bus.m_data_o), 32'h10);
                chk("bp_stall_no_pop", 32'(got.size() - base), 32'd0);
                @(posedge clk);
                #1;
                bus.m_ready_i = 1'b1;
            end
        join
        wait_got(base + 6, 200);
        chk("bp_out_count", 32'(got.size() - base), 32'd6);
        for (int i = 0; i < 6 && (base + i) < got.size(); i++)
            chk($sformatf("bp_out%0d", i), 32'(got[base + i]), 32'(8'h10 + i));

        // Random bytes with random input gaps and random sink readiness
        base     = got.size();
        perr_cnt = 0;
        ferr_cnt = 0;
        exp_q.delete();
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    logic [7:0] b;
                    b = 8'($urandom_range(0, 255));
                    exp_q.push_back(b);
                    send_frame(b, 1'b0, 1'b1, 1'b1);
                end
                bus.s_valid_i = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.m_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.m_ready_i = 1'b1;
        wait_got(base + 100, 2000);
        chk("rnd_out_count", 32'(got.size() - base), 32'd100);
        for (int i = 0; i < 100 && (base + i) < got.size(); i++)
            chk($sformatf("rnd_out%0d", i), 32'(got[base + i]), 32'(exp_q[i]));
        chk("rnd_perr_total", 32'(perr_cnt), 32'd0);
        chk("rnd_ferr_total", 32'(ferr_cnt), 32'd0);

        // Reset in mid-DATA with two bytes buffered
        bus.m_ready_i = 1'b0;
        send_frame(8'h21, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        bus.s_valid_i = 1'b0;
        @(negedge clk);
        chk("mr_pre_m_valid", 32'(bus.m_valid_o), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.s_valid_i = 1'b1;
        #1;
        chk("mr_m_valid", 32'(bus.m_valid_o), 32'd0);
        chk("mr_s_ready", 32'(bus.s_ready_o), 32'd1);
        chk("mr_m_data", 32'(bus.m_data_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.s_data_i = 1'(i);
        end
        bus.s_valid_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        perr_cnt = 0;
        ferr_cnt = 0;
        bus.m_ready_i = 1'b1;
        base = got.size();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        bus.s_valid_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mr_out_count", 32'(got.size() - base), 32'd1);
        if (got.size() > base) chk("mr_out_data", 32'(got[base]), 32'h5A);
        chk("mr_perr_total", 32'(perr_cnt), 32'd0);
        chk("mr_ferr_total", 32'(ferr_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
